data_distribution: RTL and testbench
====================================

DATA_DISTRIBUTION -- requirements
Module: data_distribution

Interface
REQ-001 SHALL have parameter COUNT_CYCLES, default 32'h000F_4240, length of the measurement window in aclk cycles.
REQ-002 SHALL have parameter FIFO_SIZE, default 5, input word buffer depth (legal 2..255).
REQ-003 SHALL have ports:
- aclk  in  1  sole clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- S00_AXIS_TVALID  in  1  input word valid.
- S00_AXIS_TDATA  in  128  four 32-bit lanes, sample in bits [32j+13:32j].
- S00_AXIS_TREADY  out  1  input word accepted when high with TVALID.
- M00_AXIS_TVALID  out  [3:0]  per-lane sample valid.
- M00_AXIS_TDATA  out  [3:0][13:0]  per-lane 14-bit sample.
- M00_AXIS_TREADY  in  [3:0]  per-lane consumer ready.
- counter_value  out  32  selected performance counter.
- ready_to_read  out  1  measurement window finished.
- command  in  32  bit 6 counter clear, bits 5:1 counter address.

Function
REQ-004 SHALL write S00_AXIS_TDATA into a circular FIFO on TVALID&TREADY; write pointer wraps FIFO_SIZE-1 -> 0.
REQ-005 S00_AXIS_TREADY SHALL equal resetn & (occupancy < FIFO_SIZE); it depends on occupancy only, so a full FIFO does not accept in the cycle it pops.
REQ-006 Lane j SHALL output head-word bits [32j+13:32j]; bits [32j+31:32j+14] ignored.
REQ-007 M00_AXIS_TVALID[j] SHALL equal resetn & FIFO non-empty & !done[j]; M00_AXIS_TDATA[j] SHALL be 0 whenever TVALID[j] is low.
REQ-008 A word accepted in cycle N SHALL appear on lane outputs in cycle N+1 when the FIFO was empty.
REQ-009 done[j] SHALL set on lane j handshake; once set, TVALID[j] stays low until head pop.
REQ-010 The head word SHALL pop in the cycle every lane is done or handshaking; all done bits clear on pop; read pointer wraps FIFO_SIZE-1 -> 0.
REQ-011 No lane SHALL present word k+1 before all four lanes consumed word k; lane order is never reordered.
REQ-012 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-013 Global cycle counter SHALL increment each cycle until equal to COUNT_CYCLES, then hold; window is open while unequal.
REQ-014 While the window is open, counters SHALL increment: addr 0 input words accepted, addr 1 words popped, addr 2 cycles with any lane valid & !ready.
REQ-015 ready_to_read SHALL be registered: 1 the cycle after the window closes.
REQ-016 When the window is closed, counter_value SHALL register the addressed counter (addr <= 2) or 0 (addr > 2); it holds while the window is open.
REQ-017 command[6]=1 SHALL synchronously clear global counter, performance counters and ready_to_read, not FIFO state.

Reset
REQ-018 resetn low SHALL asynchronously clear pointers, occupancy, done bits, all counters, counter_value and ready_to_read.
REQ-019 During reset S00_AXIS_TREADY and M00_AXIS_TVALID SHALL be 0 and M00_AXIS_TDATA SHALL be 0.

Structure
REQ-020 Shared package hti_stream_pkg SHALL hold LANES=4, LANE_WIDTH=14, LANE_STRIDE=32, command bit positions and counter addresses.
REQ-021 The 128-bit circular buffer SHALL be sub-module stream_fifo (push/pop/full/empty/head); lane control and counters stay in data_distribution.

Verification
REQ-022 Push 128'h00000ABC_00001234_00003FFF_00000001, all lanes ready -> next cycle lanes 0..3 = 0x0001, 0x3FFF, 0x1234, 0x0ABC, popped same cycle, TREADY stays 1.
REQ-023 Lanes not ready, push 6 words (FIFO_SIZE=5) -> TREADY 0 after 5th accept, 6th held; release ready -> 5 words in push order, then 6th accepted.
REQ-024 Lanes 0,1 ready, lanes 2,3 not for 3 cycles -> TVALID[1:0] drop after one handshake, no pop until lanes 2,3 accept, next word then on all lanes.
REQ-025 Push word with lane bits 31:14 all ones and sample 0x2AAA -> every lane outputs 0x2AAA.
REQ-026 COUNT_CYCLES=100, 40 words pushed and consumed, command=0x0 -> ready_to_read 1 at cycle 101, counter_value 40; command=0x2 -> 40; command=0x40 -> ready_to_read 0, counters 0.
REQ-027 Assert resetn low with 3 words buffered mid-handshake -> TVALID, TREADY 0 immediately; after release FIFO empty, no stale word output.

Source files
------------

// File: rtl/hti_stream_pkg.sv
// Shared constants for the four-lane sample stream: lane geometry,
// command-word bit positions and performance-counter addresses.
package hti_stream_pkg;

    localparam int LANES       = 4;
    localparam int LANE_WIDTH  = 14;
    localparam int LANE_STRIDE = 32;
    localparam int DATA_WIDTH  = LANES * LANE_STRIDE;

    localparam int CMD_CLEAR_BIT  = 6;
    localparam int CMD_ADDR_MSB   = 5;
    localparam int CMD_ADDR_LSB   = 1;
    localparam int CNT_ADDR_WIDTH = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

    localparam logic [CNT_ADDR_WIDTH-1:0] CNT_ADDR_ACCEPTED = 5'd0;
    localparam logic [CNT_ADDR_WIDTH-1:0] CNT_ADDR_POPPED   = 5'd1;
    localparam logic [CNT_ADDR_WIDTH-1:0] CNT_ADDR_STALL    = 5'd2;

    // Extract the 14-bit sample of one lane from a 128-bit stream word.
    function automatic logic [LANE_WIDTH-1:0] lane_sample(
        input logic [DATA_WIDTH-1:0] word,
        input int                    lane
    );
        return word[lane*LANE_STRIDE +: LANE_WIDTH];
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Circular word buffer with occupancy tracking. Push is ignored when full
// and pop is ignored when empty; simultaneous push and pop keep occupancy.
module stream_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 128
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: push-only grows, pop-only shrinks, both together hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_distribution.sv
// Fans each buffered 128-bit word out to four independent 14-bit lane
// streams. A word leaves the buffer only once every lane has taken its
// sample, so lanes stay in lock-step word order. A fixed-length measurement
// window gathers throughput and stall statistics, readable via command.
module data_distribution
    import hti_stream_pkg::*;
#(
    parameter logic [31:0] COUNT_CYCLES = 32'h000F_4240,
    parameter int          FIFO_SIZE    = 5
) (
    input  logic                              aclk,
    input  logic                              resetn,
    input  logic                              S00_AXIS_TVALID,
    input  logic [DATA_WIDTH-1:0]             S00_AXIS_TDATA,
    output logic                              S00_AXIS_TREADY,
    output logic [LANES-1:0]                  M00_AXIS_TVALID,
    output logic [LANES-1:0][LANE_WIDTH-1:0]  M00_AXIS_TDATA,
    input  logic [LANES-1:0]                  M00_AXIS_TREADY,
    output logic [31:0]                       counter_value,
    output logic                              ready_to_read,
    input  logic [31:0]                       command
);

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [DATA_WIDTH-1:0]     w_fifo_head;
    logic                      w_push;
    logic                      w_pop;
    logic [LANES-1:0]          w_lane_valid;
    logic [LANES-1:0]          w_lane_hs;
    logic                      w_stall;
    logic                      w_window_open;
    logic                      w_clear;
    logic [CNT_ADDR_WIDTH-1:0] w_addr;
    logic [31:0]               w_selected;
    logic                      w_unused_head;
    logic                      w_unused_cmd;

    logic [LANES-1:0]          r_done;
    logic [31:0]               r_cycle_cnt;
    logic [31:0]               r_cnt_accepted;
    logic [31:0]               r_cnt_popped;
    logic [31:0]               r_cnt_stall;
    logic                      r_ready_to_read;
    logic [31:0]               r_counter_value;

    stream_fifo #(
        .DEPTH (FIFO_SIZE),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (S00_AXIS_TDATA),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // Ready depends on occupancy alone: a full buffer refuses input even
    // in the cycle it pops, keeping the ready path free of lane handshakes.
    assign S00_AXIS_TREADY = resetn & ~w_fifo_full;
    assign w_push          = S00_AXIS_TVALID & S00_AXIS_TREADY;

    // Lane presentation: each lane shows the head sample until it has taken it.
    always_comb begin
        w_lane_valid   = '0;
        M00_AXIS_TDATA = '0;
        for (int j = 0; j < LANES; j++) begin
            w_lane_valid[j] = resetn & ~w_fifo_empty & ~r_done[j];
            if (w_lane_valid[j]) begin
                M00_AXIS_TDATA[j] = lane_sample(w_fifo_head, j);
            end
        end
    end

    // Upper lane bits carry no sample data.
    always_comb begin
        w_unused_head = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            w_unused_head = w_unused_head
                ^ (^w_fifo_head[j*LANE_STRIDE+LANE_WIDTH +: LANE_STRIDE-LANE_WIDTH]);
        end
    end

    assign M00_AXIS_TVALID = w_lane_valid;
    assign w_lane_hs       = w_lane_valid & M00_AXIS_TREADY;
    assign w_stall         = |(w_lane_valid & ~M00_AXIS_TREADY);
    assign w_pop           = ~w_fifo_empty & (&(r_done | w_lane_hs));

    // Per-lane done flags; all clear together when the head word retires.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_done <= '0;
        end else if (w_pop) begin
            r_done <= '0;
        end else begin
            r_done <= r_done | w_lane_hs;
        end
    end

    assign w_clear       = command[CMD_CLEAR_BIT];
    assign w_addr        = command[CMD_ADDR_MSB:CMD_ADDR_LSB];
    assign w_unused_cmd  = ^{command[31:CMD_CLEAR_BIT+1], command[0], w_unused_head};
    assign w_window_open = (r_cycle_cnt != COUNT_CYCLES);

    // Window timer counts up to COUNT_CYCLES and parks there.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_cycle_cnt <= '0;
        end else if (w_clear) begin
            r_cycle_cnt <= '0;
        end else if (w_window_open) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // Performance counters accumulate only while the window is open.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_cnt_accepted <= '0;
            r_cnt_popped   <= '0;
            r_cnt_stall    <= '0;
        end else if (w_clear) begin
            r_cnt_accepted <= '0;
            r_cnt_popped   <= '0;
            r_cnt_stall    <= '0;
        end else if (w_window_open) begin
            if (w_push) begin
                r_cnt_accepted <= r_cnt_accepted + 32'd1;
            end
            if (w_pop) begin
                r_cnt_popped <= r_cnt_popped + 32'd1;
            end
            if (w_stall) begin
                r_cnt_stall <= r_cnt_stall + 32'd1;
            end
        end
    end

    // Counter read mux; unmapped addresses read as zero.
    always_comb begin
        w_selected = '0;
        case (w_addr)
            CNT_ADDR_ACCEPTED: w_selected = r_cnt_accepted;
            CNT_ADDR_POPPED:   w_selected = r_cnt_popped;
            CNT_ADDR_STALL:    w_selected = r_cnt_stall;
            default:           w_selected = '0;
        endcase
    end

    // Window-done flag, one cycle behind the timer reaching its limit.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_ready_to_read <= 1'b0;
        end else if (w_clear) begin
            r_ready_to_read <= 1'b0;
        end else begin
            r_ready_to_read <= ~w_window_open;
        end
    end

    // Readout register tracks the selected counter only once the window closes.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_counter_value <= '0;
        end else if (!w_window_open) begin
            r_counter_value <= w_selected;
        end
    end

    assign ready_to_read = r_ready_to_read;
    assign counter_value = r_counter_value;

endmodule

// File: tb/tb_data_distribution.sv
// Directed bench for data_distribution: lane fan-out, backpressure,
// partial lane handshakes, sample masking, reset and statistics window.
module tb_data_distribution;

    logic                  aclk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  s_tvalid;
    logic [127:0]          s_tdata;
    logic                  s_tready;
    logic [3:0]            m_tvalid;
    logic [3:0][13:0]      m_tdata;
    logic [3:0]            m_tready;
    logic [31:0]           counter_value;
    logic                  ready_to_read;
    logic [31:0]           command;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    data_distribution #(
        .COUNT_CYCLES (32'd100),
        .FIFO_SIZE    (5)
    ) dut (
        .aclk            (aclk),
        .resetn          (resetn),
        .S00_AXIS_TVALID (s_tvalid),
        .S00_AXIS_TDATA  (s_tdata),
        .S00_AXIS_TREADY (s_tready),
        .M00_AXIS_TVALID (m_tvalid),
        .M00_AXIS_TDATA  (m_tdata),
        .M00_AXIS_TREADY (m_tready),
        .counter_value   (counter_value),
        .ready_to_read   (ready_to_read),
        .command         (command)
    );

    function automatic logic [127:0] mk_word(input logic [13:0] l0, input logic [13:0] l1,
                                             input logic [13:0] l2, input logic [13:0] l3);
        return {18'd0, l3, 18'd0, l2, 18'd0, l1, 18'd0, l0};
    endfunction

    function automatic logic [13:0] bp_val(input int i, input int j);
        return 14'((i + 1) * 257 + j * 3);
    endfunction

    function automatic logic [127:0] bp_word(input int i);
        return mk_word(bp_val(i, 0), bp_val(i, 1), bp_val(i, 2), bp_val(i, 3));
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; s_tvalid = 1'b1; s_tdata = '1; m_tready = 4'hF; command = '0;
        #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0h, expected 0", s_tready); end
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL rst_tvalid: got %0h, expected 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %0h, expected 0", m_tdata); end
        checks++; if (counter_value !== 32'd0) begin errors++; $display("FAIL rst_cv: got %0h, expected 0", counter_value); end
        checks++; if (ready_to_read !== 1'b0) begin errors++; $display("FAIL rst_rtr: got %0h, expected 0", ready_to_read); end
        repeat (3) tick();
        checks++; if (s_tready !== 1'b0 || m_tvalid !== 4'h0) begin errors++; $display("FAIL rst_hold: got tready %0h tvalid %0h, expected 0 0", s_tready, m_tvalid); end
        @(negedge aclk);
        resetn = 1'b1; s_tvalid = 1'b0; s_tdata = '0;
        #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rel_tready: got %0h, expected 1", s_tready); end
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL rel_tvalid: got %0h, expected 0", m_tvalid); end
    endtask

    task automatic test_single_word();
        logic [13:0] exp_l [4];
        exp_l = '{14'h0001, 14'h3FFF, 14'h1234, 14'h0ABC};
        s_tdata = 128'h00000ABC_00001234_00003FFF_00000001; s_tvalid = 1'b1; m_tready = 4'hF;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL single_tready_pre: got %0h, expected 1", s_tready); end
        tick();
        s_tvalid = 1'b0; s_tdata = '0;
        checks++; if (m_tvalid !== 4'hF) begin errors++; $display("FAIL single_tvalid: got %0h, expected f", m_tvalid); end
        for (int j = 0; j < 4; j++) begin
            checks++; if (m_tdata[j] !== exp_l[j]) begin errors++; $display("FAIL single_lane%0d: got %0h, expected %0h", j, m_tdata[j], exp_l[j]); end
        end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL single_tready: got %0h, expected 1", s_tready); end
        tick();
        checks++; if (m_tvalid !== 4'h0 || m_tdata !== '0) begin errors++; $display("FAIL single_popped: got tvalid %0h tdata %0h, expected 0 0", m_tvalid, m_tdata); end
    endtask

    task automatic test_backpressure();
        m_tready = 4'h0;
        for (int i = 0; i < 5; i++) begin
            s_tdata = bp_word(i); s_tvalid = 1'b1;
            checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: got %0h, expected 1", i, s_tready); end
            tick();
        end
        s_tdata = bp_word(5);
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_full: got %0h, expected 0", s_tready); end
        repeat (2) begin
            tick();
            checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_full_hold: got %0h, expected 0", s_tready); end
        end
        m_tready = 4'hF;
        for (int k = 0; k < 6; k++) begin
            checks++; if (m_tvalid !== 4'hF) begin errors++; $display("FAIL bp_tvalid%0d: got %0h, expected f", k, m_tvalid); end
            for (int j = 0; j < 4; j++) begin
                checks++; if (m_tdata[j] !== bp_val(k, j)) begin errors++; $display("FAIL bp_word%0d_lane%0d: got %0h, expected %0h", k, j, m_tdata[j], bp_val(k, j)); end
            end
            if (k == 0) begin
                checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_full_pop: got %0h, expected 0", s_tready); end
            end
            if (k == 1) begin
                checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_sixth: got %0h, expected 1", s_tready); end
            end
            tick();
            if (k == 1) s_tvalid = 1'b0;
        end
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL bp_drained: got %0h, expected 0", m_tvalid); end
    endtask

    task automatic test_partial_ready();
        logic [127:0] wa, wb;
        wa = mk_word(14'h0011, 14'h0022, 14'h0033, 14'h0044);
        wb = mk_word(14'h0155, 14'h0166, 14'h0177, 14'h0188);
        m_tready = 4'b0011; s_tdata = wa; s_tvalid = 1'b1;
        tick();
        s_tdata = wb;
        checks++; if (m_tvalid !== 4'hF || m_tdata[0] !== 14'h0011 || m_tdata[3] !== 14'h0044) begin errors++; $display("FAIL part_c1: got tvalid %0h tdata %0h, expected f word A", m_tvalid, m_tdata); end
        tick();
        s_tvalid = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            checks++; if (m_tvalid !== 4'b1100) begin errors++; $display("FAIL part_tvalid_c%0d: got %0h, expected c", c, m_tvalid); end
            checks++; if (m_tdata[0] !== 14'h0 || m_tdata[1] !== 14'h0 || m_tdata[2] !== 14'h0033 || m_tdata[3] !== 14'h0044) begin errors++; $display("FAIL part_tdata_c%0d: got %0h, expected 00440033_0_0", c, m_tdata); end
            tick();
        end
        m_tready = 4'hF;
        checks++; if (m_tvalid !== 4'b1100) begin errors++; $display("FAIL part_c4: got %0h, expected c", m_tvalid); end
        tick();
        checks++; if (m_tvalid !== 4'hF) begin errors++; $display("FAIL part_next_tvalid: got %0h, expected f", m_tvalid); end
        checks++; if (m_tdata[0] !== 14'h0155 || m_tdata[1] !== 14'h0166 || m_tdata[2] !== 14'h0177 || m_tdata[3] !== 14'h0188) begin errors++; $display("FAIL part_next_word: got %0h, expected word B", m_tdata); end
        tick();
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL part_drained: got %0h, expected 0", m_tvalid); end
    endtask

    task automatic test_ignore_upper();
        m_tready = 4'hF; s_tdata = {4{32'hFFFF_EAAA}}; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tdata = '0;
        for (int j = 0; j < 4; j++) begin
            checks++; if (m_tdata[j] !== 14'h2AAA) begin errors++; $display("FAIL mask_lane%0d: got %0h, expected 2aaa", j, m_tdata[j]); end
        end
        tick();
        checks++; if (m_tvalid !== 4'h0) begin errors++; $display("FAIL mask_popped: got %0h, expected 0", m_tvalid); end
    endtask

    task automatic test_reset_midstream();
        m_tready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            s_tdata = mk_word(14'(i + 1), 14'(i + 2), 14'(i + 3), 14'(i + 4)); s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 4'b0001;
        tick();
        m_tready = 4'h0;
        checks++; if (m_tvalid !== 4'b1110) begin errors++; $display("FAIL mid_handshake: got %0h, expected e", m_tvalid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 4'h0 || s_tready !== 1'b0 || m_tdata !== '0) begin errors++; $display("FAIL mid_rst: got tvalid %0h tready %0h tdata %0h, expected 0 0 0", m_tvalid, s_tready, m_tdata); end
        tick();
        @(negedge aclk);
        resetn = 1'b1; m_tready = 4'hF;
        #1;
        checks++; if (m_tvalid !== 4'h0 || s_tready !== 1'b1) begin errors++; $display("FAIL mid_rel: got tvalid %0h tready %0h, expected 0 1", m_tvalid, s_tready); end
        tick();
        checks++; if (m_tvalid !== 4'h0 || m_tdata !== '0) begin errors++; $display("FAIL mid_stale: got tvalid %0h tdata %0h, expected 0 0", m_tvalid, m_tdata); end
    endtask

    task automatic test_counters();
        int tready_drops;
        tready_drops = 0;
        @(negedge aclk);
        resetn = 1'b0;
        @(negedge aclk);
        resetn = 1'b1; command = 32'h0; m_tready = 4'hF;
        s_tvalid = 1'b1; s_tdata = mk_word(14'd1, 14'd2, 14'd3, 14'd4);
        for (int e = 1; e <= 101; e++) begin
            tick();
            if (e <= 40 && s_tready !== 1'b1) tready_drops++;
            if (e < 40) s_tdata = mk_word(14'(e + 1), 14'(e + 2), 14'(e + 3), 14'(e + 4));
            if (e == 40) s_tvalid = 1'b0;
            if (e == 50) begin
                checks++; if (counter_value !== 32'd0) begin errors++; $display("FAIL cnt_hold_open: got %0d, expected 0", counter_value); end
            end
            if (e == 100) begin
                checks++; if (ready_to_read !== 1'b0) begin errors++; $display("FAIL cnt_rtr_early: got %0h, expected 0", ready_to_read); end
            end
            if (e == 101) begin
                checks++; if (ready_to_read !== 1'b1) begin errors++; $display("FAIL cnt_rtr: got %0h, expected 1", ready_to_read); end
                checks++; if (counter_value !== 32'd40) begin errors++; $display("FAIL cnt_accepted: got %0d, expected 40", counter_value); end
            end
        end
        checks++; if (tready_drops !== 0) begin errors++; $display("FAIL cnt_tready_steady: got %0d drops, expected 0", tready_drops); end
        command = 32'h2; tick();
        checks++; if (counter_value !== 32'd40) begin errors++; $display("FAIL cnt_popped: got %0d, expected 40", counter_value); end
        command = 32'h6; tick();
        checks++; if (counter_value !== 32'd0) begin errors++; $display("FAIL cnt_addr3: got %0d, expected 0", counter_value); end
        command = 32'h0; tick();
        checks++; if (counter_value !== 32'd40) begin errors++; $display("FAIL cnt_addr0_again: got %0d, expected 40", counter_value); end
        command = 32'h4; tick();
        checks++; if (counter_value !== 32'd0) begin errors++; $display("FAIL cnt_stall: got %0d, expected 0", counter_value); end
        command = 32'h40; tick();
        command = 32'h0;
        checks++; if (ready_to_read !== 1'b0) begin errors++; $display("FAIL clr_rtr: got %0h, expected 0", ready_to_read); end
        for (int e = 1; e <= 101; e++) begin
            tick();
            if (e == 50) begin
                checks++; if (counter_value !== 32'd40) begin errors++; $display("FAIL clr_hold: got %0d, expected 40", counter_value); end
            end
            if (e == 100) begin
                checks++; if (ready_to_read !== 1'b0) begin errors++; $display("FAIL clr_rtr_early: got %0h, expected 0", ready_to_read); end
            end
            if (e == 101) begin
                checks++; if (ready_to_read !== 1'b1) begin errors++; $display("FAIL clr_rtr_again: got %0h, expected 1", ready_to_read); end
                checks++; if (counter_value !== 32'd0) begin errors++; $display("FAIL clr_counter: got %0d, expected 0", counter_value); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_partial_ready();
        test_ignore_upper();
        test_reset_midstream();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
